mdu_ctrl: RTL and testbench

- Multiply/divide unit controller for the pipelined MIPS core. Owns the HI/LO registers.
- Accepts mult/multu/div/divu/mthi/mtlo from the EX stage and models the fixed multi-cycle latency with a countdown FSM.
- Drives a busy flag; the hazard unit uses it to stall mfhi/mflo and further MDU ops.
- Sits beside the ALU in the EX stage. mfhi/mflo read the hi/lo outputs directly.

---
 rtl/mdu_ctrl_if.sv | 13 +
 rtl/mdu_ctrl.sv | 140 ++++++++++++++
 tb/tb_mdu_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mdu_ctrl_if.sv
// EX-stage to multiply/divide unit bundle: issue request, operands, busy and HI/LO results.
interface mdu_ctrl_if;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, mdu_op, rs_val, rt_val, input busy, hi, lo);
  modport slave  (input start, mdu_op, rs_val, rt_val, output busy, hi, lo);
endinterface

// File: rtl/mdu_ctrl.sv
// MIPS multiply/divide controller: owns HI/LO, models fixed mult/div latency with a countdown.
module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  mdu_ctrl_if.slave  bus
);
  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [2:0]         op_q;
  logic [31:0]        a_q, b_q;
  logic [31:0]        hi_q, lo_q, hi_d, lo_d;
  logic               busy_q;
  logic               latch_en;

  logic signed [63:0] sa64, sb64, prod_s;
  logic [63:0]        prod_u;
  logic signed [31:0] sa32, sb32;
  logic [31:0]        quot_s, rem_s, quot_u, rem_u;
  logic [31:0]        res_hi, res_lo;
  logic               res_we;

  // Result datapath, driven only by the operands captured at issue
  always_comb begin
    sa64   = 64'($signed(a_q));
    sb64   = 64'($signed(b_q));
    prod_s = sa64 * sb64;
    prod_u = 64'(a_q) * 64'(b_q);
    sa32   = $signed(a_q);
    sb32   = $signed(b_q);
    quot_s = 32'h0;
    rem_s  = 32'h0;
    quot_u = 32'h0;
    rem_u  = 32'h0;
    if (b_q != 32'h0) begin
      quot_u = a_q / b_q;
      rem_u  = a_q % b_q;
      if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
        quot_s = 32'h8000_0000;
        rem_s  = 32'h0;
      end else begin
        quot_s = 32'(sa32 / sb32);
        rem_s  = 32'(sa32 % sb32);
      end
    end
    res_hi = hi_q;
    res_lo = lo_q;
    res_we = 1'b0;
    case (op_q)
      OP_MULT:  begin {res_hi, res_lo} = prod_s; res_we = 1'b1; end
      OP_MULTU: begin {res_hi, res_lo} = prod_u; res_we = 1'b1; end
      OP_DIV:   begin res_hi = rem_s; res_lo = quot_s; res_we = (b_q != 32'h0); end
      OP_DIVU:  begin res_hi = rem_u; res_lo = quot_u; res_we = (b_q != 32'h0); end
      default:  res_we = 1'b0;
    endcase
  end

  // Next-state, countdown and HI/LO update
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    latch_en = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          case (bus.mdu_op)
            OP_MULT, OP_MULTU: begin
              latch_en = 1'b1;
              cnt_d    = CNT_W'(MULT_CYCLES);
              state_d  = RUN;
            end
            OP_DIV, OP_DIVU: begin
              latch_en = 1'b1;
              cnt_d    = CNT_W'(DIV_CYCLES);
              state_d  = RUN;
            end
            OP_MTHI: hi_d = bus.rs_val;
            OP_MTLO: lo_d = bus.rs_val;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_d = IDLE;
          if (res_we) begin
            hi_d = res_hi;
            lo_d = res_lo;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
      hi_q   <= 32'h0;
      lo_q   <= 32'h0;
      op_q   <= 3'b000;
      a_q    <= 32'h0;
      b_q    <= 32'h0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      busy_q <= (state_d == RUN);
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      if (latch_en) begin
        op_q <= bus.mdu_op;
        a_q  <= bus.rs_val;
        b_q  <= bus.rt_val;
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: latency, arithmetic, mthi/mtlo, ignore-while-busy, async reset.
module tb_mdu_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   errs = 0;
  int   cyc;

  mdu_ctrl_if m();

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (m.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count busy cycles until idle, starting from cycles already observed
  task automatic wait_idle(input int seen, output int n);
    n = m.busy ? seen : seen - 1;
    while (m.busy && n < 64) begin
      tick();
      if (m.busy) n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n_exp,
                        input logic [31:0] hi_exp, input logic [31:0] lo_exp);
    int n;
    m.start = 1'b1; m.mdu_op = op; m.rs_val = a; m.rt_val = b;
    tick();
    m.start = 1'b0; m.rs_val = $urandom; m.rt_val = $urandom;
    wait_idle(1, n);
    chk({tag, "_cycles"}, 32'(n), 32'(n_exp));
    chk({tag, "_hi"}, m.hi, hi_exp);
    chk({tag, "_lo"}, m.lo, lo_exp);
  endtask

  initial begin
    m.start = 1'b0; m.mdu_op = 3'b000; m.rs_val = 32'h0; m.rt_val = 32'h0;
    #12;
    chk("rst_busy", 32'(m.busy), 32'h0);
    chk("rst_hi", m.hi, 32'h0);
    chk("rst_lo", m.lo, 32'h0);
    @(negedge clk) reset = 1'b0;
    tick();

    run_op("mult", 3'b000, 32'hFFFF_FFFE, 32'h3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("mult_nn", 3'b000, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 5, 32'h0, 32'hF);
    run_op("multu", 3'b001, 32'hFFFF_FFFF, 32'h2, 5, 32'h1, 32'hFFFF_FFFE);
    run_op("div", 3'b010, 32'hFFFF_FFF9, 32'h2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu", 3'b011, 32'h7, 32'h2, 10, 32'h1, 32'h3);
    run_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000);

    // mthi then mtlo on consecutive edges
    m.start = 1'b1; m.mdu_op = 3'b100; m.rs_val = 32'h1234_5678;
    tick();
    chk("mthi_busy", 32'(m.busy), 32'h0);
    chk("mthi_hi", m.hi, 32'h1234_5678);
    m.mdu_op = 3'b101; m.rs_val = 32'h9ABC_DEF0;
    tick();
    m.start = 1'b0;
    chk("mtlo_busy", 32'(m.busy), 32'h0);
    chk("mtlo_lo", m.lo, 32'h9ABC_DEF0);
    chk("mtlo_hi", m.hi, 32'h1234_5678);

    // undefined opcode does nothing
    m.start = 1'b1; m.mdu_op = 3'b110; m.rs_val = 32'hDEAD_BEEF;
    tick();
    m.start = 1'b0;
    chk("undef_busy", 32'(m.busy), 32'h0);
    chk("undef_hi", m.hi, 32'h1234_5678);
    chk("undef_lo", m.lo, 32'h9ABC_DEF0);

    run_op("divu_z", 3'b011, 32'h5, 32'h0, 10, 32'h1234_5678, 32'h9ABC_DEF0);
    run_op("div_z", 3'b010, 32'hFFFF_FFF9, 32'h0, 10, 32'h1234_5678, 32'h9ABC_DEF0);

    // mult with operand changes and mtlo/mthi pulses during RUN
    m.start = 1'b1; m.mdu_op = 3'b000; m.rs_val = 32'd100; m.rt_val = 32'd7;
    tick();
    m.mdu_op = 3'b101; m.rs_val = 32'hDEAD_BEEF; m.rt_val = 32'd9;
    tick();
    chk("ign_lo", m.lo, 32'h9ABC_DEF0);
    m.mdu_op = 3'b100; m.rs_val = 32'hCAFE_F00D;
    tick();
    m.start = 1'b0;
    chk("ign_hi", m.hi, 32'h1234_5678);
    wait_idle(3, cyc);
    chk("ign_cycles", 32'(cyc), 32'd5);
    chk("ign_res_hi", m.hi, 32'h0);
    chk("ign_res_lo", m.lo, 32'd700);

    // async reset in cycle 3 of a div
    m.start = 1'b1; m.mdu_op = 3'b010; m.rs_val = 32'd100; m.rt_val = 32'd7;
    tick();
    m.start = 1'b0;
    tick();
    tick();
    chk("pre_rst_busy", 32'(m.busy), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", 32'(m.busy), 32'h0);
    chk("arst_hi", m.hi, 32'h0);
    chk("arst_lo", m.lo, 32'h0);
    @(negedge clk) reset = 1'b0;
    repeat (12) tick();
    chk("post_rst_busy", 32'(m.busy), 32'h0);
    chk("post_rst_hi", m.hi, 32'h0);
    chk("post_rst_lo", m.lo, 32'h0);

    run_op("fresh", 3'b000, 32'd6, 32'd7, 5, 32'h0, 32'd42);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
